// File: rtl/sha256_nonce_scheduler_if.sv
// Bundle between the nonce scheduler, bitcoin_hash control and the SHA-256 core array.
// master = scheduler side, slave = control/core-array side.
interface sha256_nonce_scheduler_if #(
  parameter int NUM_CORES = 4
);
  logic                       start;
  logic [31:0]                nonce_base;
  logic                       busy;
  logic                       sweep_done;
  logic [NUM_CORES-1:0]       core_start;
  logic [NUM_CORES-1:0][31:0] core_nonce;
  logic [NUM_CORES-1:0]       core_done;
  logic [NUM_CORES-1:0][31:0] core_hash;
  logic                       res_valid;
  logic                       res_ready;
  logic [31:0]                res_nonce;
  logic [31:0]                res_hash;

  modport master (
    input  start, nonce_base, core_done, core_hash, res_ready,
    output busy, sweep_done, core_start, core_nonce, res_valid, res_nonce, res_hash
  );
  modport slave (
    output start, nonce_base, core_done, core_hash, res_ready,
    input  busy, sweep_done, core_start, core_nonce, res_valid, res_nonce, res_hash
  );
endinterface

// File: rtl/sha256_nonce_scheduler.sv
// Nonce sweep scheduler: dispatches nonce_base..nonce_base+NUM_NONCES-1 over a pool of
// SHA-256 cores and returns each h0 word over a valid/ready result port.
module sha256_nonce_slot (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        launch,
  input  logic [31:0] launch_nonce,
  input  logic        accept,
  input  logic        core_done,
  input  logic [31:0] core_hash,
  output logic        avail,
  output logic        hold,
  output logic        core_start,
  output logic [31:0] nonce,
  output logic [31:0] hash
);
  typedef enum logic [1:0] {C_FREE, C_LAUNCH, C_RUN, C_HOLD} slot_e;
  slot_e st, st_nx;
  logic  seen_busy;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) st <= C_FREE;
    else          st <= st_nx;

  always_comb begin
    st_nx = st;
    case (st)
      C_FREE:   if (launch) st_nx = C_LAUNCH;
      C_LAUNCH: st_nx = C_RUN;
      C_RUN:    if (seen_busy && core_done) st_nx = C_HOLD;
      C_HOLD:   if (accept) st_nx = launch ? C_LAUNCH : C_FREE;
      default:  st_nx = C_FREE;
    endcase
  end

  // A slot whose result is being accepted this cycle can take a new job immediately.
  assign avail      = (st == C_FREE) || (st == C_HOLD && accept);
  assign hold       = (st == C_HOLD);
  assign core_start = (st == C_LAUNCH);

  // core_done is still the idle level during launch, so completion needs a low first.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      seen_busy <= 1'b0;
      nonce     <= '0;
      hash      <= '0;
    end else begin
      if (launch && avail) nonce <= launch_nonce;
      if (st == C_LAUNCH)                seen_busy <= 1'b0;
      else if (st == C_RUN && !core_done) seen_busy <= 1'b1;
      if (st == C_RUN && seen_busy && core_done) hash <= core_hash;
    end
endmodule

module sha256_nonce_scheduler #(
  parameter int NUM_CORES  = 4,
  parameter int NUM_NONCES = 16
) (
  input logic                    clk,
  input logic                    reset_n,
  sha256_nonce_scheduler_if.master bus
);
  localparam int CW = $clog2(NUM_NONCES + 1);
  localparam int SW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [CW-1:0] N_ALL  = CW'(NUM_NONCES);
  localparam logic [CW-1:0] N_LAST = CW'(NUM_NONCES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} top_e;
  typedef struct packed {
    logic [31:0] nonce;
    logic [31:0] hash;
  } res_t;

  top_e                       state, state_nx;
  logic                       start_acc, busy, sweep_done;
  logic [31:0]                base_q, launch_nonce;
  logic [CW-1:0]              issue_cnt, result_cnt;
  logic                       dispatch_en, accept, grant_vld, res_valid;
  logic [NUM_CORES-1:0]       avail, hold, cand, launch, acc_vec, core_start_v;
  logic [NUM_CORES-1:0][31:0] slot_nonce, slot_hash;
  logic [SW-1:0]              res_slot, rr_ptr, grant;
  res_t                       res_q;
  int                         idx;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;

  always_comb begin
    state_nx   = state;
    start_acc  = 1'b0;
    busy       = 1'b0;
    sweep_done = 1'b0;
    case (state)
      S_IDLE: if (bus.start) begin
        start_acc = 1'b1;
        state_nx  = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (accept && result_cnt == N_LAST) state_nx = S_DONE;
      end
      S_DONE: begin
        sweep_done = 1'b1;
        state_nx   = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // The first job launches on the start cycle itself so core_start follows start by one cycle.
  assign dispatch_en  = start_acc || (state == S_RUN && issue_cnt < N_ALL);
  assign launch_nonce = start_acc ? bus.nonce_base : base_q + 32'(issue_cnt);
  assign accept       = res_valid && bus.res_ready;

  always_comb begin
    launch  = '0;
    cand    = '0;
    acc_vec = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (dispatch_en && avail[i] && launch == '0) launch[i] = 1'b1;
      cand[i]    = hold[i] && !(res_valid && res_slot == SW'(i));
      acc_vec[i] = accept && res_slot == SW'(i);
    end
  end

  // Round-robin over pending results, starting just after the last grant.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (!grant_vld && cand[SW'(idx)]) begin
        grant_vld = 1'b1;
        grant     = SW'(idx);
      end
    end
  end

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_slot
    sha256_nonce_slot u_slot (
      .clk          (clk),
      .reset_n      (reset_n),
      .launch       (launch[g]),
      .launch_nonce (launch_nonce),
      .accept       (acc_vec[g]),
      .core_done    (bus.core_done[g]),
      .core_hash    (bus.core_hash[g]),
      .avail        (avail[g]),
      .hold         (hold[g]),
      .core_start   (core_start_v[g]),
      .nonce        (slot_nonce[g]),
      .hash         (slot_hash[g])
    );
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      base_q     <= '0;
      issue_cnt  <= '0;
      result_cnt <= '0;
      res_valid  <= 1'b0;
      res_q      <= '0;
      res_slot   <= '0;
      rr_ptr     <= SW'(NUM_CORES - 1);
    end else begin
      if (start_acc) base_q <= bus.nonce_base;
      if (start_acc)    issue_cnt <= CW'(|launch);
      else if (|launch) issue_cnt <= issue_cnt + 1'b1;
      if (start_acc)   result_cnt <= '0;
      else if (accept) result_cnt <= result_cnt + 1'b1;
      // Presented data only changes when the port is empty or being drained.
      if (grant_vld && (!res_valid || bus.res_ready)) begin
        res_valid <= 1'b1;
        res_q     <= '{nonce: slot_nonce[grant], hash: slot_hash[grant]};
        res_slot  <= grant;
        rr_ptr    <= grant;
      end else if (accept) begin
        res_valid <= 1'b0;
      end
    end

  assign bus.busy       = busy;
  assign bus.sweep_done = sweep_done;
  assign bus.core_start = core_start_v;
  assign bus.core_nonce = slot_nonce;
  assign bus.res_valid  = res_valid;
  assign bus.res_nonce  = res_q.nonce;
  assign bus.res_hash   = res_q.hash;
endmodule

// File: tb/tb_sha256_nonce_scheduler.sv
// Directed bench: three scheduler instances (4x16, 4x4, 1x3) driven by stub cores with
// per-core programmable latency; results are collected and checked against the stub hash.
module tb_sha256_nonce_scheduler;
  typedef struct {
    logic [31:0] n;
    logic [31:0] h;
  } res_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  sha256_nonce_scheduler_if #(.NUM_CORES(4)) a_if ();
  sha256_nonce_scheduler_if #(.NUM_CORES(4)) b_if ();
  sha256_nonce_scheduler_if #(.NUM_CORES(1)) c_if ();

  sha256_nonce_scheduler #(.NUM_CORES(4), .NUM_NONCES(16)) dut_a (.clk(clk), .reset_n(reset_n), .bus(a_if));
  sha256_nonce_scheduler #(.NUM_CORES(4), .NUM_NONCES(4))  dut_b (.clk(clk), .reset_n(reset_n), .bus(b_if));
  sha256_nonce_scheduler #(.NUM_CORES(1), .NUM_NONCES(3))  dut_c (.clk(clk), .reset_n(reset_n), .bus(c_if));

  function automatic logic [31:0] hfn(input logic [31:0] n);
    return (n ^ 32'hDEAD_BEEF) + {n[15:0], n[31:16]};
  endfunction

  // Stub cores: slots 0-3 -> dut_a, 4-7 -> dut_b, 8 -> dut_c.
  logic        cs [9];
  logic [31:0] cn [9];
  logic        sd [9];
  logic [31:0] sh [9];
  int          scnt [9];
  int          lat [9];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cs[i]   = a_if.core_start[i];
      cn[i]   = a_if.core_nonce[i];
      cs[i+4] = b_if.core_start[i];
      cn[i+4] = b_if.core_nonce[i];
    end
    cs[8] = c_if.core_start[0];
    cn[8] = c_if.core_nonce[0];
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      a_if.core_done[i] = sd[i];
      a_if.core_hash[i] = sh[i];
      b_if.core_done[i] = sd[i+4];
      b_if.core_hash[i] = sh[i+4];
    end
    c_if.core_done[0] = sd[8];
    c_if.core_hash[0] = sh[8];
  end

  for (genvar g = 0; g < 9; g++) begin : g_stub
    always @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        sd[g] <= 1'b1; sh[g] <= '0; scnt[g] <= 0;
      end else if (cs[g]) begin
        sd[g] <= 1'b0; scnt[g] <= lat[g];
      end else if (scnt[g] == 1) begin
        sd[g] <= 1'b1; sh[g] <= hfn(cn[g]); scnt[g] <= 0;
      end else if (scnt[g] > 1) begin
        scnt[g] <= scnt[g] - 1;
      end
  end

  // Monitors
  res_t qa[$], qb[$], qc[$];
  int   cyc = 0, sd_a = 0, sd_b = 0, sd_c = 0, csa = 0;
  int   c_st[$], c_acc[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (a_if.res_valid && a_if.res_ready) qa.push_back('{a_if.res_nonce, a_if.res_hash});
    if (b_if.res_valid && b_if.res_ready) qb.push_back('{b_if.res_nonce, b_if.res_hash});
    if (c_if.res_valid && c_if.res_ready) begin
      qc.push_back('{c_if.res_nonce, c_if.res_hash});
      c_acc.push_back(cyc);
    end
    if (c_if.core_start[0]) c_st.push_back(cyc);
    if (a_if.sweep_done) sd_a <= sd_a + 1;
    if (b_if.sweep_done) sd_b <= sd_b + 1;
    if (c_if.sweep_done) sd_c <= sd_c + 1;
    csa <= csa + $countones(a_if.core_start);
  end

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sd_of(input int which);
    case (which)
      0:       return sd_a;
      1:       return sd_b;
      default: return sd_c;
    endcase
  endfunction

  task automatic pulse_start(input int which, input logic [31:0] base);
    @(negedge clk);
    case (which)
      0:       begin a_if.start = 1'b1; a_if.nonce_base = base; end
      1:       begin b_if.start = 1'b1; b_if.nonce_base = base; end
      default: begin c_if.start = 1'b1; c_if.nonce_base = base; end
    endcase
    @(negedge clk);
    a_if.start = 1'b0; b_if.start = 1'b0; c_if.start = 1'b0;
  endtask

  task automatic wait_sd(input int which, input int target, input string tag);
    int n = 0;
    while (sd_of(which) < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(sd_of(which)), 64'(target));
  endtask

  task automatic check_sweep(input int which, input logic [31:0] base, input int n, input string tag);
    res_t        q[$];
    logic [31:0] mask = '0;
    int          bad = 0;
    case (which)
      0:       q = qa;
      1:       q = qb;
      default: q = qc;
    endcase
    foreach (q[i]) begin
      logic [31:0] off;
      off = q[i].n - base;
      if (off >= 32'(n) || mask[off[4:0]]) bad++;
      else mask[off[4:0]] = 1'b1;
      if (q[i].h !== hfn(q[i].n)) bad++;
    end
    chk({tag, "_cnt"}, 64'(q.size()), 64'(n));
    chk({tag, "_set"}, 64'(mask), (64'd1 << n) - 64'd1);
    chk({tag, "_bad"}, 64'(bad), 64'd0);
  endtask

  initial begin
    int          n, unstable, cs_snap, sd_snap;
    logic [31:0] snap_n, snap_h;
    logic [31:0] exp2 [4];
    exp2 = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};

    reset_n = 1'b0;
    a_if.start = 1'b0; b_if.start = 1'b0; c_if.start = 1'b0;
    a_if.nonce_base = '0; b_if.nonce_base = '0; c_if.nonce_base = '0;
    a_if.res_ready = 1'b0; b_if.res_ready = 1'b0; c_if.res_ready = 1'b0;
    for (int i = 0; i < 9; i++) lat[i] = 70;
    lat[8] = 20;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_busy", 64'(a_if.busy), 64'd0);
    chk("rst_sweep_done", 64'(a_if.sweep_done), 64'd0);
    chk("rst_core_start", 64'(a_if.core_start), 64'd0);
    chk("rst_core_nonce", 64'(|a_if.core_nonce), 64'd0);
    chk("rst_res", {31'd0, a_if.res_valid, a_if.res_nonce | a_if.res_hash}, 64'd0);
    reset_n = 1'b1;
    a_if.res_ready = 1'b1; b_if.res_ready = 1'b1;

    // 1: base 0, 16 jobs over 4 cores, ready always high
    pulse_start(0, 32'h0);
    chk("t1_busy", 64'(a_if.busy), 64'd1);
    chk("t1_first_launch", 64'(a_if.core_start), 64'h1);
    chk("t1_first_nonce", 64'(a_if.core_nonce[0]), 64'h0);
    wait_sd(0, 1, "t1_sweep_done");
    check_sweep(0, 32'h0, 16, "t1");
    repeat (5) @(negedge clk);
    chk("t1_single_done", 64'(sd_a), 64'd1);
    chk("t1_busy_after", 64'(a_if.busy), 64'd0);

    // 2: wrapping nonces on the 4-job instance
    pulse_start(1, 32'hFFFF_FFFE);
    wait_sd(1, 1, "t2_sweep_done");
    chk("t2_cnt", 64'(qb.size()), 64'd4);
    for (int i = 0; i < qb.size() && i < 4; i++) begin
      chk($sformatf("t2_nonce%0d", i), 64'(qb[i].n), 64'(exp2[i]));
      chk($sformatf("t2_hash%0d", i), 64'(qb[i].h), 64'(hfn(exp2[i])));
    end

    // 3: consumer stall holds the result and blocks relaunch
    qa.delete();
    a_if.res_ready = 1'b0;
    cs_snap = csa;
    pulse_start(0, 32'h100);
    n = 0;
    while (!a_if.res_valid && n < 500) begin @(negedge clk); n++; end
    chk("t3_valid", 64'(a_if.res_valid), 64'd1);
    chk("t3_first_nonce", 64'(a_if.res_nonce), 64'h100);
    chk("t3_first_hash", 64'(a_if.res_hash), 64'(hfn(32'h100)));
    chk("t3_launched", 64'(csa - cs_snap), 64'd4);
    snap_n = a_if.res_nonce; snap_h = a_if.res_hash;
    cs_snap = csa; unstable = 0;
    repeat (200) begin
      @(negedge clk);
      if (a_if.res_valid !== 1'b1 || a_if.res_nonce !== snap_n || a_if.res_hash !== snap_h) unstable++;
    end
    chk("t3_stable", 64'(unstable), 64'd0);
    chk("t3_no_relaunch", 64'(csa - cs_snap), 64'd0);
    a_if.res_ready = 1'b1;
    wait_sd(0, 2, "t3_sweep_done");
    check_sweep(0, 32'h100, 16, "t3");

    // 4: cores 1 and 3 complete on the same cycle
    qa.delete();
    lat[0] = 40; lat[1] = 52; lat[2] = 60; lat[3] = 50;
    pulse_start(0, 32'h200);
    wait_sd(0, 3, "t4_sweep_done");
    check_sweep(0, 32'h200, 16, "t4");
    if (qa.size() >= 4) begin
      chk("t4_order0", 64'(qa[0].n), 64'h200);
      chk("t4_order1", 64'(qa[1].n), 64'h201);
      chk("t4_order2", 64'(qa[2].n), 64'h203);
      chk("t4_order3", 64'(qa[3].n), 64'h202);
    end
    for (int i = 0; i < 4; i++) lat[i] = 70;

    // 5: reset mid-sweep, then a clean sweep with a start pulsed while busy
    pulse_start(0, 32'h300);
    repeat (100) @(negedge clk);
    sd_snap = sd_a;
    reset_n = 1'b0;
    #1;
    chk("t5_rst_busy", 64'(a_if.busy), 64'd0);
    chk("t5_rst_core_start", 64'(a_if.core_start), 64'd0);
    chk("t5_rst_core_nonce", 64'(|a_if.core_nonce), 64'd0);
    chk("t5_rst_res", {31'd0, a_if.res_valid, a_if.res_nonce | a_if.res_hash}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("t5_no_done", 64'(sd_a), 64'(sd_snap));
    qa.delete();
    pulse_start(0, 32'h400);
    repeat (3) @(negedge clk);
    pulse_start(0, 32'h999);
    wait_sd(0, sd_snap + 1, "t5_sweep_done");
    check_sweep(0, 32'h400, 16, "t5");
    repeat (10) @(negedge clk);
    chk("t5_single_done", 64'(sd_a), 64'(sd_snap + 1));
    chk("t5_busy_after", 64'(a_if.busy), 64'd0);

    // 6: single core, launches strictly follow accepts
    c_st.delete(); c_acc.delete(); qc.delete();
    pulse_start(2, 32'h50);
    n = 0;
    while (!c_if.res_valid && n < 200) begin @(negedge clk); n++; end
    chk("t6_valid", 64'(c_if.res_valid), 64'd1);
    repeat (30) @(negedge clk);
    chk("t6_held_launches", 64'(c_st.size()), 64'd1);
    c_if.res_ready = 1'b1;
    wait_sd(2, 1, "t6_sweep_done");
    chk("t6_cnt", 64'(qc.size()), 64'd3);
    for (int i = 0; i < qc.size() && i < 3; i++)
      chk($sformatf("t6_nonce%0d", i), 64'(qc[i].n), 64'(32'h50 + 32'(i)));
    chk("t6_launch_cnt", 64'(c_st.size()), 64'd3);
    for (int k = 1; k < c_st.size() && k <= c_acc.size(); k++)
      chk($sformatf("t6_serial%0d", k), 64'(c_st[k]), 64'(c_acc[k-1] + 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
